// File: rtl/psr_pkg.sv
// Shared types and constants for the PSR flag-update requester.
// Flag positions follow the P register layout {n,v,x,b,d,i,z,c}.
package psr_pkg;

  localparam int FLAG_N = 7;
  localparam int FLAG_V = 6;
  localparam int FLAG_X = 5;
  localparam int FLAG_B = 4;
  localparam int FLAG_D = 3;
  localparam int FLAG_I = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  // Bit positions inside a {N,V,Z,C} nibble (flag_mask and resolved results).
  localparam int MASK_N = 3;
  localparam int MASK_V = 2;
  localparam int MASK_Z = 1;
  localparam int MASK_C = 0;

  typedef struct packed {
    logic [3:0] mask;
    logic       n;
    logic       v;
    logic       z;
    logic       c;
  } psr_upd_t;

  localparam int PSR_UPD_W = $bits(psr_upd_t);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACK_LOW = 2'd2
  } psr_req_state_t;

  function automatic psr_upd_t make_upd(input logic [3:0] mask,
                                        input logic [7:0] result,
                                        input logic       carry,
                                        input logic       overflow);
    psr_upd_t upd;
    upd.mask = mask;
    upd.n    = result[7];
    upd.v    = overflow;
    upd.z    = (result == 8'h00);
    upd.c    = carry;
    return upd;
  endfunction

  // Masked flags come from the stored ALU values, the rest from the live P value.
  function automatic logic [3:0] resolve_flags(input psr_upd_t   upd,
                                               input logic [7:0] psr);
    logic [3:0] alu_flags;
    logic [3:0] cur_flags;
    alu_flags = {upd.n, upd.v, upd.z, upd.c};
    cur_flags = {psr[FLAG_N], psr[FLAG_V], psr[FLAG_Z], psr[FLAG_C]};
    return (upd.mask & alu_flags) | (~upd.mask & cur_flags);
  endfunction

endpackage

// File: rtl/psr_upd_fifo.sv
// Synchronous FIFO of pending flag updates. Push is ignored when full and
// pop when empty; a simultaneous push and pop leaves occupancy unchanged.
module psr_upd_fifo
  import psr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [PSR_UPD_W-1:0] push_data,
  input  logic                 pop,
  output logic [PSR_UPD_W-1:0] pop_data,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  psr_upd_t      mem_q [DEPTH];
  psr_upd_t      mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = psr_upd_t'(push_data);
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/psr_update_requester.sv
// Buffers ALU flag results and writes them to the processor status register
// through a four-phase request/acknowledge handshake with per-phase timeout.
module psr_update_requester
  import psr_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       fclk,
  input  logic       reset,
  input  logic       alu_valid,
  output logic       alu_ready,
  input  logic [7:0] alu_result,
  input  logic       alu_carry_out,
  input  logic       alu_overflow,
  input  logic [3:0] flag_mask,
  input  logic [7:0] psr_in,
  output logic       psr_update_request,
  input  logic       ack_update_request,
  output logic       n_result,
  output logic       v_result,
  output logic       z_result,
  output logic       c_result,
  output logic       busy,
  output logic       ack_timeout_err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  psr_req_state_t       state_q, state_d;
  logic                 req_q, req_d;
  logic [3:0]           res_q, res_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 err_q, err_d;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [PSR_UPD_W-1:0] fifo_in;
  logic [PSR_UPD_W-1:0] fifo_head;
  logic                 tmo_expired;

  assign fifo_in     = make_upd(flag_mask, alu_result, alu_carry_out, alu_overflow);
  assign fifo_push   = alu_valid && !fifo_full;
  assign fifo_pop    = (state_q == ST_IDLE) && !fifo_empty;
  assign tmo_expired = (tmo_q == TMO_LAST);

  psr_upd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (fclk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(fifo_in),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // The counter restarts on every state entry; the cycle that would make it
  // reach ACK_TIMEOUT aborts the handshake and drops the in-flight entry.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    res_d   = res_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (!fifo_empty) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          res_d   = resolve_flags(psr_upd_t'(fifo_head), psr_in);
        end
      end
      ST_REQ: begin
        if (ack_update_request) begin
          state_d = ST_ACK_LOW;
          req_d   = 1'b0;
          tmo_d   = '0;
        end else if (tmo_expired) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      ST_ACK_LOW: begin
        if (!ack_update_request) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
        end else if (tmo_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        tmo_d   = '0;
      end
    endcase
  end

  always_ff @(posedge fclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      res_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign alu_ready          = !fifo_full;
  assign psr_update_request = req_q;
  assign n_result           = res_q[MASK_N];
  assign v_result           = res_q[MASK_V];
  assign z_result           = res_q[MASK_Z];
  assign c_result           = res_q[MASK_C];
  assign busy               = !fifo_empty || (state_q != ST_IDLE);
  assign ack_timeout_err    = err_q;

endmodule

// File: tb/tb_psr_update_requester.sv
// Self-checking bench: the bench plays the status register, keeps its own P
// value and a queue of expected updates, and checks every request it sees.
module tb_psr_update_requester;

  localparam int FIFO_DEPTH  = 2;
  localparam int ACK_TIMEOUT = 15;
  localparam int ACK_NORMAL  = 0;
  localparam int ACK_NEVER   = 1;
  localparam int ACK_STUCK   = 2;

  typedef struct packed {
    logic [3:0] mask;
    logic [3:0] aluFlags;
  } upd_t;

  logic       fclk = 1'b0;
  logic       reset = 1'b1;
  logic       alu_valid = 1'b0;
  logic       alu_ready;
  logic [7:0] alu_result = 8'h00;
  logic       alu_carry_out = 1'b0;
  logic       alu_overflow = 1'b0;
  logic [3:0] flag_mask = 4'h0;
  logic [7:0] psr_in = 8'h00;
  logic       psr_update_request;
  logic       ack_update_request = 1'b0;
  logic       n_result, v_result, z_result, c_result;
  logic       busy;
  logic       ack_timeout_err;

  int         checks = 0;
  int         failures = 0;
  int         riseCount = 0;
  int         ackMode = ACK_NORMAL;
  int         ackWait = 0;
  bit         randomAck = 1'b0;
  logic       reqSeen = 1'b0;
  logic [7:0] psrReg = 8'h00;
  logic [7:0] nextPsr = 8'h00;
  upd_t       headUpd;
  upd_t       expQ[$];

  psr_update_requester #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .fclk              (fclk),
    .reset             (reset),
    .alu_valid         (alu_valid),
    .alu_ready         (alu_ready),
    .alu_result        (alu_result),
    .alu_carry_out     (alu_carry_out),
    .alu_overflow      (alu_overflow),
    .flag_mask         (flag_mask),
    .psr_in            (psr_in),
    .psr_update_request(psr_update_request),
    .ack_update_request(ack_update_request),
    .n_result          (n_result),
    .v_result          (v_result),
    .z_result          (z_result),
    .c_result          (c_result),
    .busy              (busy),
    .ack_timeout_err   (ack_timeout_err)
  );

  always #5 fclk = ~fclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // P value after a full four-flag write of one update on top of p.
  function automatic logic [7:0] applyUpdate(input upd_t u, input logic [7:0] p);
    int         pos [4];
    logic [7:0] r;
    pos = '{7, 6, 1, 0};
    r   = p;
    for (int i = 0; i < 4; i++) begin
      if (u.mask[3 - i]) r[pos[i]] = u.aluFlags[3 - i];
    end
    return r;
  endfunction

  // Status register model: checks each new request, acks after ackWait cycles.
  always @(negedge fclk) begin
    if (reset) begin
      ack_update_request = 1'b0;
      reqSeen = 1'b0;
    end else begin
      if (psr_update_request && !reqSeen) begin
        riseCount++;
        checkOutput("req_has_entry", expQ.size() > 0, 1);
        if (expQ.size() > 0) begin
          headUpd = expQ.pop_front();
          nextPsr = applyUpdate(headUpd, psrReg);
          checkOutput("req_flags", {n_result, v_result, z_result, c_result},
                      {nextPsr[7], nextPsr[6], nextPsr[1], nextPsr[0]});
        end
        ackWait = randomAck ? $urandom_range(0, 3) : 0;
      end
      reqSeen = psr_update_request;
      if (ackMode == ACK_NEVER) begin
        ack_update_request = 1'b0;
      end else if (psr_update_request && !ack_update_request) begin
        if (ackWait == 0) begin
          ack_update_request = 1'b1;
          psrReg = nextPsr;
        end else begin
          ackWait--;
        end
      end else if (!psr_update_request && ack_update_request && ackMode == ACK_NORMAL) begin
        ack_update_request = 1'b0;
      end
    end
    psr_in = psrReg;
  end

  // Called at a negedge; returns at the negedge after the capturing edge.
  task automatic applyStimulus(input logic [7:0] res, input logic c, input logic v,
                               input logic [3:0] m);
    bit   accepted;
    upd_t u;
    accepted      = 1'b0;
    alu_valid     = 1'b1;
    alu_result    = res;
    alu_carry_out = c;
    alu_overflow  = v;
    flag_mask     = m;
    for (int k = 0; k < 200 && !accepted; k++) begin
      accepted = alu_ready;
      @(negedge fclk);
    end
    if (accepted) begin
      u.mask     = m;
      u.aluFlags = {res[7], v, (res == 8'h00), c};
      expQ.push_back(u);
    end else begin
      alu_valid = 1'b0;
      checkOutput("accept_timeout", alu_ready, 1);
    end
  endtask

  task automatic idleInputs();
    alu_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    for (int k = 0; k < budget && (busy || ack_update_request); k++) @(negedge fclk);
    checkOutput("wait_idle", busy, 0);
  endtask

  task automatic waitReq(input logic level, input int budget);
    for (int k = 0; k < budget && psr_update_request !== level; k++) @(negedge fclk);
    checkOutput("wait_req", psr_update_request, level);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    alu_valid = 1'b0;
    @(negedge fclk);
    checkOutput("reset_req", psr_update_request, 0);
    checkOutput("reset_results", {n_result, v_result, z_result, c_result}, 0);
    checkOutput("reset_ready", alu_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_err", ack_timeout_err, 0);
    expQ.delete();
    reset = 1'b0;
  endtask

  initial begin
    int base;
    int cnt;
    resetDut();

    // Basic update with full mask and a one-cycle ack.
    applyStimulus(8'h80, 1'b1, 1'b0, 4'b1111);
    idleInputs();
    checkOutput("lat_edge1", psr_update_request, 0);
    @(negedge fclk);
    checkOutput("lat_edge2", psr_update_request, 1);
    checkOutput("basic_flags", {n_result, v_result, z_result, c_result}, 4'b1001);
    @(negedge fclk);
    checkOutput("req_fall", psr_update_request, 0);
    checkOutput("ack_low_busy", busy, 1);
    @(negedge fclk);
    checkOutput("basic_busy_done", busy, 0);

    // Partial mask keeps N/V from the current P value.
    psrReg = 8'hC3;
    @(negedge fclk);
    applyStimulus(8'h00, 1'b0, 1'b0, 4'b0011);
    idleInputs();
    waitIdle(50);
    checkOutput("partial_flags", {n_result, v_result, z_result, c_result}, 4'b1110);

    // Back-to-back pushes fill the FIFO while the first request is in flight.
    base = riseCount;
    applyStimulus(8'h80, 1'b0, 1'b1, 4'b1111);
    applyStimulus(8'h00, 1'b1, 1'b0, 4'b1111);
    applyStimulus(8'h7F, 1'b0, 1'b0, 4'b1010);
    checkOutput("burst_full_ready", alu_ready, 0);
    applyStimulus(8'h01, 1'b1, 1'b1, 4'b0101);
    idleInputs();
    waitIdle(100);
    checkOutput("burst_requests", riseCount - base, 4);
    checkOutput("burst_queue_empty", expQ.size(), 0);

    // Timeout in REQ: first entry dropped, queued entry still requested.
    ackMode = ACK_NEVER;
    base = riseCount;
    applyStimulus(8'h55, 1'b1, 1'b0, 4'b1111);
    applyStimulus(8'hF0, 1'b0, 1'b1, 4'b1111);
    idleInputs();
    waitReq(1'b1, 20);
    cnt = 0;
    for (int k = 0; k < 40 && psr_update_request; k++) begin
      cnt++;
      @(negedge fclk);
    end
    ackMode = ACK_NORMAL;
    checkOutput("timeout_req_len", cnt, ACK_TIMEOUT);
    checkOutput("timeout_err", ack_timeout_err, 1);
    waitIdle(50);
    checkOutput("timeout_next_served", riseCount - base, 2);
    checkOutput("timeout_err_sticky", ack_timeout_err, 1);

    // Stuck ack in ACK_LOW.
    resetDut();
    ackMode = ACK_STUCK;
    applyStimulus(8'h33, 1'b0, 1'b0, 4'b1111);
    idleInputs();
    waitReq(1'b1, 20);
    waitReq(1'b0, 20);
    cnt = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      cnt++;
      @(negedge fclk);
    end
    checkOutput("stuck_ack_len", cnt, ACK_TIMEOUT);
    checkOutput("stuck_ack_err", ack_timeout_err, 1);
    ackMode = ACK_NORMAL;
    waitIdle(20);

    // Randomized traffic with random ack delays.
    randomAck = 1'b1;
    base = riseCount;
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        idleInputs();
        waitIdle(200);
        psrReg = 8'($urandom);
        @(negedge fclk);
      end
      applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        idleInputs();
        repeat ($urandom_range(0, 4)) @(negedge fclk);
      end
    end
    idleInputs();
    waitIdle(400);
    checkOutput("random_requests", riseCount - base, 30);
    checkOutput("random_queue_empty", expQ.size(), 0);
    randomAck = 1'b0;

    // Reset mid-REQ with two entries queued.
    ackMode = ACK_NEVER;
    applyStimulus(8'h11, 1'b1, 1'b0, 4'b1111);
    applyStimulus(8'h22, 1'b0, 1'b1, 4'b1111);
    applyStimulus(8'h44, 1'b1, 1'b1, 4'b1111);
    idleInputs();
    waitReq(1'b1, 20);
    resetDut();
    ackMode = ACK_NORMAL;
    base = riseCount;
    repeat (40) @(negedge fclk);
    checkOutput("post_reset_requests", riseCount - base, 0);
    checkOutput("post_reset_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
